// File: rtl/l1_flush_ctrl.sv
// l1_flush_ctrl
//
// Walks the L1 lines in order (lineSel = 0 .. LINES-1). Each dirty line
// (lineStatus != 0) is written back to memory, one transaction at a time.
// Clean lines are skipped.
//
// Memory handshake: memReq is the valid and memAck is the ready.
// - memReq rises after the FETCH edge of a dirty line.
// - memReq, memAddr and memData stay constant until the first clock edge
//   that samples memAck high. That edge completes the transfer and drops
//   memReq.
// - memAck is ignored whenever no request is pending.
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   flushStart           flush request, only accepted while idle
//   lineSel              line index presented to the L1 read port
//   lineData/Addr/Status combinational read data of the selected line
//   memReq/Addr/Data     write-back request
//   memAck               write-back accept
//   busy                 high from flush accept until completion
//   done                 one-cycle completion pulse
//   flushCount           dirty lines written back in the current/last flush
//   stateDbg             current FSM state, for observation only
module l1_flush_ctrl #(
  parameter int LINES = 4,
  parameter int DW    = 8,
  parameter int AW    = 3,
  parameter int SW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flushStart,
  output logic [1:0]    lineSel,
  input  logic [DW-1:0] lineData,
  input  logic [AW-1:0] lineAddr,
  input  logic [SW-1:0] lineStatus,
  output logic          memReq,
  output logic [AW-1:0] memAddr,
  output logic [DW-1:0] memData,
  input  logic          memAck,
  output logic          busy,
  output logic          done,
  output logic [2:0]    flushCount,
  output logic [2:0]    stateDbg
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WRITE = 3'd2,
    NEXT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [1:0] LAST_LINE = 2'(LINES - 1);

  state_t state, nextState;

  // Control strobes decoded from the current state and inputs.
  logic startFlush;
  logic captureLine;
  logic issueWrite;
  logic ackWrite;
  logic advanceLine;
  logic finishFlush;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (flushStart) nextState = FETCH;
      FETCH:   nextState = (lineStatus != '0) ? WRITE : NEXT;
      WRITE:   if (memAck) nextState = NEXT;
      NEXT:    nextState = (lineSel == LAST_LINE) ? DONE : FETCH;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Output decode. lineStatus is only looked at in FETCH, and memAck only
  // in WRITE, so changes on those inputs in other states have no effect.
  always_comb begin
    startFlush  = (state == IDLE) && flushStart;
    captureLine = (state == FETCH);
    issueWrite  = (state == FETCH) && (lineStatus != '0);
    ackWrite    = (state == WRITE) && memAck;
    advanceLine = (state == NEXT) && (lineSel != LAST_LINE);
    finishFlush = (state == DONE);
  end

  // Registered datapath and outputs. The address and data of every fetched
  // line are captured, even for clean lines, so that they are already in
  // place when memReq rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lineSel    <= '0;
      memReq     <= 1'b0;
      memAddr    <= '0;
      memData    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      flushCount <= '0;
    end else begin
      done <= finishFlush;
      if (startFlush) begin
        lineSel    <= '0;
        flushCount <= '0;
        busy       <= 1'b1;
      end
      if (captureLine) begin
        memAddr <= lineAddr;
        memData <= lineData;
      end
      if (issueWrite) memReq <= 1'b1;
      if (ackWrite) begin
        memReq     <= 1'b0;
        flushCount <= flushCount + 3'd1;
      end
      if (advanceLine) lineSel <= lineSel + 2'd1;
      if (finishFlush) busy <= 1'b0;
    end
  end

  assign stateDbg = state;

endmodule

// File: tb/tb_l1_flush_ctrl.sv
// Testbench for l1_flush_ctrl.
//
// The L1 contents are held in small per-line tables. For each flush, the
// reference model lists the dirty lines in scan order. From that list it
// derives three things:
//   - the expected write-backs,
//   - the completion edge: start + 2*LINES + 1, plus (1 + wait) per dirty line,
//   - the final write-back count.
// The memory-side responder inserts the planned number of wait cycles
// before it accepts each write.
module tb_l1_flush_ctrl;
  localparam int LINES = 4;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          flushStart;
  logic [1:0]    lineSel;
  logic [DW-1:0] lineData;
  logic [AW-1:0] lineAddr;
  logic [SW-1:0] lineStatus;
  logic          memReq;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memData;
  logic          memAck;
  logic          busy;
  logic          done;
  logic [2:0]    flushCount;
  logic [2:0]    stateDbg;

  l1_flush_ctrl #(.LINES(LINES), .DW(DW), .AW(AW), .SW(SW)) dut (
    .clk(clk), .rst(rst), .flushStart(flushStart), .lineSel(lineSel),
    .lineData(lineData), .lineAddr(lineAddr), .lineStatus(lineStatus),
    .memReq(memReq), .memAddr(memAddr), .memData(memData), .memAck(memAck),
    .busy(busy), .done(done), .flushCount(flushCount), .stateDbg(stateDbg)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- L1 model ----------------
  logic [AW-1:0] l_addr[LINES];
  logic [DW-1:0] l_data[LINES];
  logic [SW-1:0] l_stat[LINES];
  int            w_tab[LINES];

  always_comb begin
    lineAddr   = l_addr[lineSel];
    lineData   = l_data[lineSel];
    lineStatus = l_stat[lineSel];
  end

  // ---------------- scoreboard state ----------------
  logic [AW+DW-1:0] exp_q[$];
  int  wait_q[$];
  int  dcnt_q[$];
  int  dcyc_q[$];
  int  n_vec = 0;
  int  n_err = 0;
  bit  active = 0;
  int  last_cnt = 0;
  int  cur_wait = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference model. Given the edge that accepts the flush, push the
  // expected write-backs, the ack waits and the completion record.
  // Returns the edge on which done is expected.
  function automatic int push_expect(input int start_edge);
    int t;
    int cnt;
    t = start_edge + 2 * LINES + 1;
    cnt = 0;
    for (int i = 0; i < LINES; i++) begin
      if (l_stat[i] != 0) begin
        exp_q.push_back({l_addr[i], l_data[i]});
        wait_q.push_back(w_tab[i]);
        t += 1 + w_tab[i];
        cnt++;
      end
    end
    dcnt_q.push_back(cnt);
    dcyc_q.push_back(t);
    return t;
  endfunction

  // ---------------- memory responder ----------------
  // Acks after the planned number of wait cycles. While no request is
  // pending, it drives random noise on memAck.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      cur_wait = -1;
      memAck   = 1'b0;
    end else if (memReq) begin
      if (cur_wait < 0) cur_wait = (wait_q.size() != 0) ? wait_q.pop_front() : 0;
      if (cur_wait == 0) memAck = 1'b1;
      else begin
        memAck = 1'b0;
        cur_wait--;
      end
    end else begin
      cur_wait = -1;
      memAck   = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        active = 0;
        check("done_with_memreq", {31'd0, memReq}, 32'd0);
        if (dcnt_q.size() == 0) flag("unexpected_done");
        else begin
          int ec;
          int et;
          ec = dcnt_q.pop_front();
          et = dcyc_q.pop_front();
          check("flush_count", {29'd0, flushCount}, ec);
          check("done_cycle", cyc, et);
          check("final_line_sel", {30'd0, lineSel}, LINES - 1);
          last_cnt = ec;
        end
      end
      check("busy", {31'd0, busy}, {31'd0, active});
      if (memReq) begin
        if (exp_q.size() == 0) flag("unexpected_memreq");
        else begin
          check("mem_addr_data", {21'd0, memAddr, memData}, {21'd0, exp_q[0]});
          if (memAck) void'(exp_q.pop_front());
        end
      end
      if (!active && !done) check("idle_count_hold", {29'd0, flushCount}, last_cnt);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_queues();
    exp_q.delete();
    wait_q.delete();
    dcnt_q.delete();
    dcyc_q.delete();
  endtask

  task automatic wait_done_count(input int remaining);
    int k;
    k = 0;
    while (dcnt_q.size() > remaining && k < 300) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (dcnt_q.size() > remaining) begin
      flag("done_timeout");
      clear_queues();
      active = 0;
    end
  endtask

  task automatic run_flush();
    @(posedge clk);
    #1;
    void'(push_expect(cyc + 1));
    flushStart = 1'b1;
    @(posedge clk);
    #1;
    active = 1;
    flushStart = 1'b0;
    wait_done_count(0);
  endtask

  task automatic set_line(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s, input int w);
    l_addr[i] = a;
    l_data[i] = d;
    l_stat[i] = s;
    w_tab[i]  = w;
  endtask

  task automatic clean_table();
    for (int i = 0; i < LINES; i++) set_line(i, AW'(i), DW'(8'h10 + i), '0, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int d1;
    int k;
    rst = 1'b1;
    flushStart = 1'b0;
    memAck = 1'b0;
    clean_table();
    #1;
    check("rst_memreq", {31'd0, memReq}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_count", {29'd0, flushCount}, 0);
    check("rst_linesel", {30'd0, lineSel}, 0);
    check("rst_mem_addr_data", {21'd0, memAddr, memData}, 0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;

    // All lines clean: done 9 cycles after accept, no write-backs.
    clean_table();
    run_flush();

    // Two dirty lines accepted immediately: done at cycle 11.
    clean_table();
    set_line(0, 3'b001, 8'hAA, 2'd1, 0);
    set_line(1, 3'b011, 8'h55, 2'd1, 0);
    run_flush();

    // Backpressure: five wait cycles on the line-2 write.
    clean_table();
    set_line(2, 3'b111, 8'h0F, 2'd2, 5);
    run_flush();

    // Retrigger: flushStart held high for the whole first flush. The
    // second flush starts only on the idle cycle after done.
    clean_table();
    set_line(1, 3'b101, 8'hC3, 2'd3, 1);
    set_line(3, 3'b010, 8'h3C, 2'd1, 0);
    @(posedge clk);
    #1;
    d1 = push_expect(cyc + 1);
    void'(push_expect(d1 + 1));
    flushStart = 1'b1;
    @(posedge clk);
    #1;
    active = 1;
    wait_done_count(1);
    @(posedge clk);
    #1;
    active = 1;
    flushStart = 1'b0;
    wait_done_count(0);

    // Reset in the middle of a write-back.
    clean_table();
    set_line(0, 3'b110, 8'h99, 2'd1, 20);
    @(posedge clk);
    #1;
    void'(push_expect(cyc + 1));
    flushStart = 1'b1;
    @(posedge clk);
    #1;
    active = 1;
    flushStart = 1'b0;
    k = 0;
    while (!memReq && k < 50) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("memreq_before_reset", {31'd0, memReq}, 1);
    rst = 1'b1;
    #1;
    check("reset_memreq_drop", {31'd0, memReq}, 0);
    check("reset_busy", {31'd0, busy}, 0);
    check("reset_count", {29'd0, flushCount}, 0);
    check("reset_done", {31'd0, done}, 0);
    check("reset_linesel", {30'd0, lineSel}, 0);
    clear_queues();
    active = 0;
    last_cnt = 0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    repeat (6) @(negedge clk);

    // After reset, a full scan from line 0.
    set_line(0, 3'b100, 8'h81, 2'd2, 2);
    set_line(3, 3'b001, 8'h7E, 2'd1, 1);
    run_flush();

    // Randomized flushes.
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < LINES; i++)
        set_line(i, AW'($urandom()), DW'($urandom()), SW'($urandom_range(0, 3)),
                 $urandom_range(0, 3));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      run_flush();
    end

    repeat (3) @(negedge clk);
    #1;
    check("leftover_writes", exp_q.size(), 0);
    check("leftover_dones", dcnt_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/l1_flush_ctrl.md
L1_FLUSH_CTRL -- requirements
Module: l1_flush_ctrl

Interface
REQ-001 The block SHALL have parameter LINES, default 4, meaning number of L1 lines scanned per flush.
REQ-002 The block SHALL have parameter DW, default 8, meaning data width; AW, default 3, meaning address width; SW, default 2, meaning status width.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset; ports are listed below.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 flushStart  input  1  request to flush; sampled only in IDLE.
REQ-007 lineSel  output  2  L1 line index driven to the L1 read port.
REQ-008 lineData  input  DW  data of the selected line, combinational from L1.
REQ-009 lineAddr  input  AW  address tag of the selected line.
REQ-010 lineStatus  input  SW  status of the selected line; nonzero means write-back is needed.
REQ-011 memReq  output  1  memory write request.
REQ-012 memAddr  output  AW  memory write address.
REQ-013 memData  output  DW  memory write data.
REQ-014 memAck  input  1  memory write accept.
REQ-015 busy  output  1  high from flush accept until DONE.
REQ-016 done  output  1  one-cycle pulse at flush completion.
REQ-017 flushCount  output  3  lines written back in the current or last flush.

Function
REQ-018 The FSM SHALL have the states IDLE, FETCH, WRITE, NEXT and DONE, all registered on clk.
REQ-019 IDLE: when flushStart=1, the block SHALL set lineSel=0, clear flushCount, set busy=1 and go to FETCH; otherwise it stays in IDLE.
REQ-020 FETCH: the block SHALL capture lineAddr and lineData into memAddr and memData.
- If lineStatus!=0, it SHALL set memReq=1 and go to WRITE.
- Otherwise it SHALL go to NEXT.
REQ-021 WRITE: memReq, memAddr and memData SHALL be held stable until memAck is sampled high.
- On that edge it SHALL clear memReq, increment flushCount and go to NEXT.
REQ-022 memAck SHALL be ignored in every state other than WRITE.
REQ-023 NEXT: if lineSel==LINES-1, the block SHALL go to DONE; otherwise it SHALL increment lineSel and go to FETCH.
REQ-024 DONE: the block SHALL assert done=1 for exactly one cycle and clear busy on the same edge, then go to IDLE; lineSel SHALL retain its final value.
REQ-025 flushStart asserted while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-026 Latency from the flushStart edge to the done pulse SHALL be 2*LINES+1 cycles plus (1 + wait cycles) per dirty line; with all lines clean this is 9 cycles.
REQ-027 memReq SHALL never be high in the same cycle as done.
REQ-028 At most one memReq transaction SHALL be outstanding at any time.
REQ-029 flushCount SHALL hold its value after DONE until the next accepted flush.
REQ-030 lineStatus SHALL be evaluated only in FETCH; changes in any other state SHALL have no effect.

Reset
REQ-031 While rst=1, independent of clk, the block SHALL force state=IDLE, lineSel=0, memReq=0, memAddr=0, memData=0, busy=0, done=0 and flushCount=0.
REQ-032 A reset during WRITE SHALL drop memReq immediately and abandon the flush, with no done pulse.
REQ-033 After rst deasserts, the first flushStart SHALL start a complete scan from line 0.

Verification
REQ-034 All clean: statuses {0,0,0,0}, pulse flushStart -> memReq never high, done pulses 9 cycles after flushStart, flushCount=0.
REQ-035 Mixed: line0 addr=001 data=AA status=1, line1 addr=011 data=55 status=1, lines 2–3 status=0, memAck tied high -> two writes (001/AA, then 011/55), flushCount=2, done at cycle 11.
REQ-036 Backpressure: line2 addr=111 data=0F status=2, memAck held low 5 cycles -> memReq, memAddr=111 and memData=0F stable for all 6 cycles, one write, flushCount=1.
REQ-037 Retrigger: flushStart held high for the whole flush -> no second flush until IDLE is reached, and the following flush restarts at lineSel=0.
REQ-038 Reset mid-write: rst asserted while memReq=1 -> memReq=0 immediately, busy=0, done never pulses, flushCount=0.
